// File: rtl/imm_ext_pkg.sv
// Shared types and widths for the immediate-extension arbiter.
package imm_ext_pkg;

    localparam int RAW_W = 24;
    localparam int OUT_W = 32;

    // Extension mode carried with each request
    typedef enum logic [1:0] {
        IMM8  = 2'b00,
        IMM12 = 2'b01,
        BR24  = 2'b10,
        RSVD  = 2'b11
    } imm_mode_e;

    // Occupancy of the one-entry output stage
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/imm_ext_arbiter_extension_unit.sv
// Combinational immediate extension datapath. The reserved mode passes the
// raw field through unchanged; callers decide how to treat it.
module extension_unit
    import imm_ext_pkg::*;
(
    input  logic [RAW_W-1:0] imm,
    input  imm_mode_e        mode,
    output logic [OUT_W-1:0] data
);

    // Select the extension form for the requested mode
    always_comb begin
        data = '0;
        case (mode)
            IMM8:    data = {24'b0, imm[7:0]};
            IMM12:   data = {20'b0, imm[11:0]};
            BR24:    data = {{6{imm[23]}}, imm, 2'b00};
            default: data = {8'b0, imm};
        endcase
    end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate-extension datapath between
// N_REQ requesters, with a one-entry registered response stage.
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*RAW_W-1:0] req_imm,
    input  logic [N_REQ*2-1:0]     req_sel,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [OUT_W-1:0]       rsp_data,
    output logic                   rsp_err
);

    out_state_e        state_reg;
    logic [ID_W-1:0]   last_grant_reg;
    logic [ID_W-1:0]   rsp_id_reg;
    logic [OUT_W-1:0]  rsp_data_reg;
    logic              rsp_err_reg;

    logic [RAW_W-1:0]  imm_arr  [N_REQ];
    imm_mode_e         mode_arr [N_REQ];

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              can_accept;
    logic              transfer;
    logic [RAW_W-1:0]  sel_imm;
    imm_mode_e         sel_mode;
    logic [OUT_W-1:0]  ext_data;
    logic [OUT_W-1:0]  data_next;
    logic              err_next;

    // Unpack per-requester fields and form the per-requester accept
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign imm_arr[gi]   = req_imm[gi*RAW_W +: RAW_W];
            assign mode_arr[gi]  = imm_mode_e'(req_sel[gi*2 +: 2]);
            assign req_ready[gi] = grant_found && (grant_idx == ID_W'(gi)) && can_accept;
        end
    endgenerate

    // Round-robin search starting just above the last grant. The first loop
    // finds the lowest valid requester (the wrap-around winner); the second
    // overrides it with the lowest valid requester above last_grant, if any.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) > last_grant_reg)) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    // Output stage can take a new result when empty or draining; nothing is
    // accepted while reset is held
    assign can_accept = ((state_reg == EMPTY) || rsp_ready) && !reset;
    assign transfer   = grant_found && can_accept;

    assign sel_imm  = imm_arr[grant_idx];
    assign sel_mode = mode_arr[grant_idx];

    extension_unit u_ext (
        .imm  (sel_imm),
        .mode (sel_mode),
        .data (ext_data)
    );

    // Reserved mode produces a defined zero result flagged as an error
    always_comb begin
        err_next  = (sel_mode == RSVD);
        data_next = err_next ? '0 : ext_data;
    end

    // Output register, EMPTY/FULL state and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= EMPTY;
            last_grant_reg <= ID_W'(N_REQ - 1);
            rsp_id_reg     <= '0;
            rsp_data_reg   <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            if (transfer) begin
                state_reg      <= FULL;
                last_grant_reg <= grant_idx;
                rsp_id_reg     <= grant_idx;
                rsp_data_reg   <= data_next;
                rsp_err_reg    <= err_next;
            end else if ((state_reg == FULL) && rsp_ready) begin
                state_reg <= EMPTY;
            end
        end
    end

    assign rsp_valid = (state_reg == FULL);
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Self-checking bench for imm_ext_arbiter: directed scenarios plus a
// randomized phase checked every cycle against a behavioural model.
module tb_imm_ext_arbiter;

    localparam int N   = 2;
    localparam int IDW = $clog2(N);

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*24-1:0]  req_imm;
    logic [N*2-1:0]   req_sel;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [31:0]      rsp_data;
    logic             rsp_err;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    bit          m_valid = 1'b0;
    int          m_id    = 0;
    logic [31:0] m_data  = '0;
    bit          m_err   = 1'b0;
    int          m_last  = N - 1;
    logic [N-1:0] acc_mask = '0;
    logic [N-1:0] pend     = '0;
    logic [23:0] pend_imm [N];
    logic [1:0]  pend_sel [N];

    imm_ext_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_imm   (req_imm),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Extension result computed arithmetically from the mode rules
    function automatic logic [31:0] ref_ext(input logic [23:0] imm, input logic [1:0] sel);
        int s;
        case (sel)
            2'd0: return 32'(imm % 256);
            2'd1: return 32'(imm % 4096);
            2'd2: begin
                s = imm[23] ? int'(imm) - (1 << 24) : int'(imm);
                return 32'(s * 4);
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_grant(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] ref_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        if (reset) return r;
        if (m_valid && !rsp_ready) return r;
        g = ref_grant(req_valid, m_last);
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic set_req(input int i, input logic [23:0] imm, input logic [1:0] sel);
        req_imm[i*24 +: 24] = imm;
        req_sel[i*2 +: 2]   = sel;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: advances on each clock edge, resets asynchronously
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid  = 1'b0;
            m_id     = 0;
            m_data   = '0;
            m_err    = 1'b0;
            m_last   = N - 1;
            acc_mask = '0;
            pend     = '0;
        end else begin : mdl
            logic [N-1:0] rdy;
            int g;
            for (int i = 0; i < N; i++) begin
                if (pend[i] && req_valid[i]) begin
                    tests++;
                    if (req_imm[i*24 +: 24] !== pend_imm[i] || req_sel[i*2 +: 2] !== pend_sel[i]) begin
                        fails++;
                        $display("FAIL hold%0d: fields changed while pending at %0t", i, $time);
                    end
                end
            end
            rdy      = ref_ready();
            acc_mask = req_valid & rdy;
            if (acc_mask != '0) begin
                g       = ref_grant(req_valid, m_last);
                m_valid = 1'b1;
                m_id    = g;
                m_data  = ref_ext(req_imm[g*24 +: 24], req_sel[g*2 +: 2]);
                m_err   = (req_sel[g*2 +: 2] == 2'b11);
                m_last  = g;
                $display("[TB] xfer id=%0d data=%08h err=%0d t=%0t", m_id, m_data, m_err, $time);
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
            end
            pend = req_valid & ~acc_mask;
            for (int i = 0; i < N; i++) begin
                pend_imm[i] = req_imm[i*24 +: 24];
                pend_sel[i] = req_sel[i*2 +: 2];
            end
        end
    end

    // Compare process: outputs and combinational accepts every cycle
    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready), 32'(ref_ready()));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            chk("rsp_id",   32'(rsp_id),  32'(m_id));
            chk("rsp_data", rsp_data,     m_data);
            chk("rsp_err",  32'(rsp_err), 32'(m_err));
        end
    end

    logic [23:0] t_imm [3] = '{24'hFFFABC, 24'h800001, 24'h000010};
    logic [1:0]  t_sel [3] = '{2'b01, 2'b10, 2'b10};
    logic [31:0] t_exp [3] = '{32'h00000ABC, 32'hFE000004, 32'h00000040};

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_imm   = '0;
        req_sel   = '0;
        rsp_ready = 1'b1;

        // Pin the model against hand-computed values
        chk("pin_imm8",  ref_ext(24'h0000AB, 2'b00), 32'h000000AB);
        chk("pin_imm12", ref_ext(24'hFFFABC, 2'b01), 32'h00000ABC);
        chk("pin_br_neg", ref_ext(24'h800001, 2'b10), 32'hFE000004);
        chk("pin_br_pos", ref_ext(24'h000010, 2'b10), 32'h00000040);
        chk("pin_rsvd",  ref_ext(24'h123456, 2'b11), 32'h00000000);
        chk("pin_rr",    32'(ref_grant(2'b11, 1)), 32'd0);

        repeat (3) step();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id",    32'(rsp_id),    32'd0);
        chk("rst_data",  rsp_data,       32'd0);
        chk("rst_err",   32'(rsp_err),   32'd0);
        req_valid = 2'b11;
        #1 chk("rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        reset = 1'b0;
        step();

        // Single request
        set_req(0, 24'h0000AB, 2'b00);
        req_valid = 2'b01;
        #1 chk("single_ready", 32'(req_ready), 32'h1);
        step();
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_id",    32'(rsp_id),    32'd0);
        chk("single_data",  rsp_data,       32'h000000AB);
        req_valid = '0;
        step();

        // Mode coverage on requester 1
        for (int k = 0; k < 3; k++) begin
            set_req(1, t_imm[k], t_sel[k]);
            req_valid = 2'b10;
            step();
            chk("mode_id",   32'(rsp_id), 32'd1);
            chk("mode_data", rsp_data,    t_exp[k]);
            req_valid = '0;
            step();
        end

        // Contention: alternating grants
        set_req(0, 24'h000011, 2'b00);
        set_req(1, 24'h000022, 2'b00);
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1 chk("onehot", 32'($countones(req_ready)), 32'd1);
            step();
            chk("rr_id", 32'(rsp_id), 32'(k % 2));
        end

        // Back-pressure while FULL
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_id",   32'(rsp_id), 32'd1);
            chk("bp_data", rsp_data,    32'h00000022);
            step();
        end
        rsp_ready = 1'b1;
        #1 chk("bp_resume_ready", 32'(req_ready), 32'h1);
        step();
        chk("bp_resume_valid", 32'(rsp_valid), 32'd1);
        chk("bp_resume_id",    32'(rsp_id),    32'd0);
        chk("bp_resume_data",  rsp_data,       32'h00000011);
        req_valid = '0;
        step();
        step();

        // Reserved mode then a normal request
        set_req(0, 24'h123456, 2'b11);
        req_valid = 2'b01;
        step();
        chk("rsvd_err",  32'(rsp_err), 32'd1);
        chk("rsvd_data", rsp_data,     32'd0);
        set_req(0, 24'h0000CD, 2'b00);
        step();
        chk("after_rsvd_err",  32'(rsp_err), 32'd0);
        chk("after_rsvd_data", rsp_data,     32'h000000CD);
        req_valid = '0;

        // Reset while FULL with last grant 0
        rsp_ready = 1'b0;
        chk("pre_reset_valid", 32'(rsp_valid), 32'd1);
        #1 reset = 1'b1;
        #1 chk("async_reset_valid", 32'(rsp_valid), 32'd0);
        set_req(0, 24'h000055, 2'b00);
        set_req(1, 24'h000066, 2'b01);
        req_valid = 2'b11;
        #1 chk("reset_ready", 32'(req_ready), 32'd0);
        step();
        step();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        #1 chk("post_reset_ready", 32'(req_ready), 32'h1);
        step();
        chk("post_reset_id", 32'(rsp_id), 32'd0);
        step();
        chk("post_reset_id2", 32'(rsp_id), 32'd1);
        req_valid = '0;
        step();

        // Randomized phase
        for (int c = 0; c < 800; c++) begin
            reset = (c % 250 == 249);
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !acc_mask[i])) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    set_req(i, 24'($urandom), 2'($urandom_range(0, 3)));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        reset     = 1'b0;
        req_valid = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_ext_arbiter.md
# imm_ext_arbiter

Shares one immediate-extension datapath between up to N_REQ requesters, such as fetch-stage branch-target precompute and decode-stage operand immediates. Each requester offers a 24-bit raw field and a 2-bit extension mode over a valid/ready handshake. A round-robin arbiter grants one request per cycle and extends the field combinationally. The 32-bit result is registered into a one-entry output stage, returned with the requester id over a valid/ready response port.

## Interface
- N_REQ, 2, number of requesters; legal range 2..8.
- ID_W, $clog2(N_REQ), width of response id (derived; not overridden).
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_imm  in  N_REQ*24  packed raw fields; requester i at [24*i +: 24].
- req_sel  in  N_REQ*2  packed modes; requester i at [2*i +: 2].
- rsp_valid  out  1  output register holds a result.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  index of requester that produced rsp_data.
- rsp_data  out  32  extended immediate.
- rsp_err  out  1  request used reserved mode 2'b11.

## Operation
- Modes:
  - 00: zero-extend imm[7:0].
  - 01: zero-extend imm[11:0].
  - 10: sign-extend imm[23:0], then shift left 2, giving {6{imm[23]}, imm, 2'b00}.
  - 11: rsp_data = 32'd0 and rsp_err = 1. The result is defined, never x.
- can_accept = !rsp_valid | rsp_ready, meaning the output register is empty or is draining this cycle.
- Arbitration:
  - Round-robin over req_valid.
  - Search starts at last_grant+1, modulo N_REQ.
  - The first valid requester found is granted.
- req_ready[i] = grant[i] & can_accept.
  - req_ready depends combinationally on req_valid and rsp_ready.
  - Requesters must not gate req_valid on req_ready.
- Transfer occurs when req_valid[i] & req_ready[i]. On that edge:
  - rsp_data, rsp_id and rsp_err load.
  - rsp_valid is set.
  - last_grant is set to i.
- Response handshake:
  - rsp_valid & rsp_ready with no new transfer clears rsp_valid.
  - With a simultaneous new transfer, the register reloads and rsp_valid stays 1.
- last_grant updates only on a transfer. It is unchanged on stall or idle cycles.
- Requester protocol: once req_valid[i] is asserted, req_imm and req_sel for i are held until accepted. The bench flags any violation.
- State is two-valued: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY to FULL on a transfer.
  - FULL to EMPTY on a drain with no transfer.
  - FULL to FULL on a drain plus transfer, or on a stall.

## Timing
- Reset values, applied asynchronously on reset high:
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - last_grant=N_REQ-1, so requester 0 has first priority.
- req_ready is combinational and is 0 while reset is asserted.
- Latency: a request accepted at edge k produces rsp_valid=1 after edge k, i.e. 1 cycle.
- Throughput: 1 result per cycle when rsp_ready is held high.
- While rsp_valid & !rsp_ready:
  - all req_ready are 0.
  - rsp_data, rsp_id and rsp_err are stable.
- Fairness: with all requesters continuously valid and no stalls, grants follow 0,1,...,N_REQ-1,0,...
- A single active requester is granted every cycle.
- Reset asserted mid-transfer: the in-flight result is discarded and rsp_valid drops immediately, without waiting for the clock. After reset release, requester 0 wins the first contention.

## Structure
- Package imm_ext_pkg:
  - mode enum: IMM8=2'b00, IMM12=2'b01, BR24=2'b10, RSVD=2'b11.
  - constants RAW_W=24 and OUT_W=32.
- Sub-module: instantiate the existing extension_unit as the combinational datapath on the granted request's fields. The wrapper overrides mode 11 to 0 and sets err.
- The round-robin grant logic stays inline; its state is only the last_grant register.

## Test plan
- Single request, reset done: req0 sends imm=24'h0000AB, sel=00.
  - Same cycle: req_ready[0]=1.
  - Next cycle: rsp_valid=1, rsp_id=0, rsp_data=32'h000000AB.
- Mode coverage on req1:
  - imm=24'hFFFABC, sel=01 gives 32'h00000ABC.
  - imm=24'h800001, sel=10 gives 32'hFE000004.
  - imm=24'h000010, sel=10 gives 32'h00000040.
- Contention: N_REQ=2, both valid for 6 cycles, rsp_ready=1.
  - rsp_id sequence is 0,1,0,1,0,1.
  - Exactly one req_ready bit is high each cycle.
- Back-pressure: rsp_ready=0 for 3 cycles while FULL.
  - req_ready is 0 throughout.
  - rsp_data and rsp_id are unchanged.
  - On the cycle rsp_ready returns to 1, the next request is accepted the same cycle, with no bubble.
- Reserved mode: sel=11, imm=24'h123456 gives rsp_err=1 and rsp_data=0. The next sel=00 request gives rsp_err=0.
- Reset mid-operation: assert reset while rsp_valid=1 and last_grant=0.
  - rsp_valid drops immediately.
  - After release with both requesters valid, the first grant goes to requester 0.
